// File: rtl/regfile_sb.sv
// ----------------------------------------------------------------------------
// regfile_sb
// General-purpose register file with a per-register write scoreboard.
//
// Two combinational read ports serve the ID stage. A write port accepts
// write-back results, and a write-through bypass makes a result that is
// landing this cycle visible on the read ports immediately. Each register
// (except r0) has a small pending-write counter. The counter is incremented
// when ID issues an instruction that targets the register, and decremented
// when the write-back arrives. A read of a register that still has pending
// writes raises stall_o (RAW hazard). An issue to a register whose counter is
// saturated also raises stall_o (scoreboard full).
//
// Ports:
//   clk                              rising-edge clock
//   rst                              asynchronous reset, active-low
//   re1/raddr1/rdata1                read port 1 (combinational)
//   re2/raddr2/rdata2                read port 2 (combinational)
//   issue_valid/issue_we/issue_waddr instruction leaving ID and its destination
//   wb_we/wb_waddr/wb_wdata          write-back port
//   flush                            synchronous pipeline flush, clears scoreboard
//   stall_o                          RAW or scoreboard-full hazard, ID must hold
//   err_o                            sticky: write-back with no pending write
// ----------------------------------------------------------------------------
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int MAX_PEND = 3,
    parameter int CNT_W    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic              issue_valid,
    input  logic              issue_we,
    input  logic [ADDR_W-1:0] issue_waddr,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_waddr,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic              flush,
    output logic              stall_o,
    output logic              err_o
);

    // Current register contents and pending counts, one entry per register.
    logic [DATA_W-1:0] w_regs [NUM_REGS];
    logic [CNT_W-1:0]  w_cnt  [NUM_REGS];

    logic              r_err;
    logic              w_stall;
    logic              w_haz1;
    logic              w_haz2;
    logic              w_full;
    logic [CNT_W-1:0]  w_cnt_rd1;
    logic [CNT_W-1:0]  w_cnt_rd2;
    logic [CNT_W-1:0]  w_cnt_iss;
    logic [CNT_W-1:0]  w_cnt_wb;
    logic              w_wb_hit1;
    logic              w_wb_hit2;

    // ------------------------------------------------------------------
    // Per-register storage and pending counter
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                // r0 is hard-wired to zero and never tracked.
                assign w_regs[gi] = '0;
                assign w_cnt[gi]  = '0;
            end else begin : g_live
                logic [DATA_W-1:0] r_data;
                logic [CNT_W-1:0]  r_cnt;
                logic              w_wb_sel;
                logic              w_inc;
                logic              w_dec;

                assign w_wb_sel = wb_we && (wb_waddr == ADDR_W'(gi));
                // Issues are only counted when ID actually advances.
                assign w_inc    = issue_valid && issue_we && !w_stall && !flush &&
                                  (issue_waddr == ADDR_W'(gi));
                // A write-back against an empty counter is an error, not a decrement.
                assign w_dec    = w_wb_sel && (r_cnt != '0) && !flush;

                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        r_data <= '0;
                    end else if (w_wb_sel) begin
                        r_data <= wb_wdata;
                    end
                end

                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        r_cnt <= '0;
                    end else if (flush) begin
                        r_cnt <= '0;
                    end else if (w_inc && !w_dec) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end else if (w_dec && !w_inc) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                assign w_regs[gi] = r_data;
                assign w_cnt[gi]  = r_cnt;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read ports with write-through bypass
    // ------------------------------------------------------------------
    assign w_wb_hit1 = wb_we && (wb_waddr == raddr1);
    assign w_wb_hit2 = wb_we && (wb_waddr == raddr2);

    always_comb begin
        rdata1 = '0;
        // Gated by rst so the bypass path cannot leak data while in reset.
        if (rst && re1 && (raddr1 != '0)) begin
            rdata1 = w_wb_hit1 ? wb_wdata : w_regs[raddr1];
        end
    end

    always_comb begin
        rdata2 = '0;
        if (rst && re2 && (raddr2 != '0)) begin
            rdata2 = w_wb_hit2 ? wb_wdata : w_regs[raddr2];
        end
    end

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    assign w_cnt_rd1 = w_cnt[raddr1];
    assign w_cnt_rd2 = w_cnt[raddr2];
    assign w_cnt_iss = w_cnt[issue_waddr];
    assign w_cnt_wb  = w_cnt[wb_waddr];

    // The last outstanding write landing this cycle is served by the bypass,
    // so it resolves the hazard in the same cycle.
    assign w_haz1 = re1 && (raddr1 != '0) && (w_cnt_rd1 != '0) &&
                    !(w_wb_hit1 && (w_cnt_rd1 == CNT_W'(1)));
    assign w_haz2 = re2 && (raddr2 != '0) && (w_cnt_rd2 != '0) &&
                    !(w_wb_hit2 && (w_cnt_rd2 == CNT_W'(1)));

    // A saturated counter can still accept the issue when a write-back to the
    // same register retires one entry in the same cycle.
    assign w_full = issue_valid && issue_we && (issue_waddr != '0) &&
                    (w_cnt_iss == CNT_W'(MAX_PEND)) &&
                    !(wb_we && (wb_waddr == issue_waddr));

    assign w_stall = w_haz1 || w_haz2 || w_full;
    assign stall_o = w_stall;

    // ------------------------------------------------------------------
    // Sticky error: write-back with nothing outstanding
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (!flush && wb_we && (wb_waddr != '0) && (w_cnt_wb == '0)) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;

endmodule
